// File: rtl/home_event_scheduler_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// home_pkg : event codes, scheduler state and round-robin helpers
// Rev 1.0
// ------------------------------------------------------------------
package home_pkg;

  localparam logic [2:0] EVT_NONE = 3'b000;
  localparam logic [2:0] EVT_FD   = 3'b001;
  localparam logic [2:0] EVT_RD   = 3'b010;
  localparam logic [2:0] EVT_FIRE = 3'b011;
  localparam logic [2:0] EVT_WIN  = 3'b100;
  localparam logic [2:0] EVT_HEAT = 3'b101;
  localparam logic [2:0] EVT_COOL = 3'b110;

  localparam int RR_N = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Round-robin slot order: FD, RD, WIN, HEAT, COOL
  function automatic logic [2:0] rr_code(input logic [2:0] idx);
    logic [2:0] code;
    code = EVT_NONE;
    case (idx)
      3'd0:    code = EVT_FD;
      3'd1:    code = EVT_RD;
      3'd2:    code = EVT_WIN;
      3'd3:    code = EVT_HEAT;
      3'd4:    code = EVT_COOL;
      default: code = EVT_NONE;
    endcase
    return code;
  endfunction

  // Returns {found, slot}; scanning farthest-first so the nearest request wins
  function automatic logic [3:0] rr_pick(input logic [4:0] req, input logic [2:0] ptr);
    logic [3:0] res;
    int         k;
    res = 4'b0000;
    for (int i = RR_N - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % RR_N;
      if (req[k]) res = {1'b1, 3'(k)};
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/home_event_scheduler_if.sv
`default_nettype none
// ------------------------------------------------------------------
// home_event_scheduler_if : event valid/ready channel to the controller
// Rev 1.0
// ------------------------------------------------------------------
interface home_event_scheduler_if;

  logic       evt_valid;
  logic [2:0] evt_code;
  logic       evt_ready;

  modport master (output evt_valid, output evt_code, input evt_ready);
  modport slave  (input evt_valid, input evt_code, output evt_ready);

endinterface
`default_nettype wire

// File: rtl/home_event_scheduler_debounce.sv
`default_nettype none
// ------------------------------------------------------------------
// sensor_debounce : flips after DEB_CYCLES consecutive mismatches
// Rev 1.0
// ------------------------------------------------------------------
module sensor_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic rise
);

  localparam int            CW        = $clog2(DEB_CYCLES) + 1;
  localparam logic [CW-1:0] C_CNT_MAX = CW'(DEB_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          r_deb;
  logic          w_flip;

  assign w_flip = (raw != r_deb) && (r_cnt == C_CNT_MAX);
  assign rise   = w_flip & raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_deb <= 1'b0;
      r_cnt <= '0;
    end else if (raw == r_deb) begin
      r_cnt <= '0;
    end else if (w_flip) begin
      r_deb <= raw;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/home_event_scheduler.sv
`default_nettype none
// ------------------------------------------------------------------
// home_event_scheduler : debounced sensor events, FIRE-first RR issue
// Rev 1.0
// ------------------------------------------------------------------
module home_event_scheduler
  import home_pkg::*;
#(
  parameter int         DEB_CYCLES  = 4,
  parameter int         HOLD_CYCLES = 8,
  parameter logic [6:0] T_LOW       = 7'd50,
  parameter logic [6:0] T_HIGH      = 7'd70
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sfd,
  input  logic                   srd,
  input  logic                   sw,
  input  logic                   sfa,
  input  logic [6:0]             st,
  home_event_scheduler_if.master evt,
  output logic [5:0]             pend,
  output logic                   busy
);

  localparam int            HW         = $clog2(HOLD_CYCLES) + 1;
  localparam logic [HW-1:0] C_HOLD_MAX = HW'(HOLD_CYCLES - 1);

  logic [3:0]    w_raw;
  logic [3:0]    w_rise;
  logic [3:0]    w_clr;
  logic [3:0]    r_pend_lat;
  logic          r_heat_lvl;
  logic          r_cool_lvl;
  logic          r_heat_mask;
  logic          r_cool_mask;
  logic [5:0]    w_pend;
  logic [4:0]    w_rr_req;
  logic [3:0]    w_pick;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [2:0]    r_code;
  logic [2:0]    w_code_nxt;
  logic [2:0]    r_gidx;
  logic [2:0]    w_gidx_nxt;
  logic [2:0]    r_ptr;
  logic [HW-1:0] r_hold_cnt;
  logic [HW-1:0] w_hold_nxt;
  logic          w_offer;
  logic          w_accept;

  // Latched sources in pend-bit order: FD, RD, FIRE, WIN
  assign w_raw = {sw, sfa, srd, sfd};

  generate
    for (genvar g = 0; g < 4; g++) begin : g_deb
      sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk  (clk),
        .rst  (rst),
        .raw  (w_raw[g]),
        .rise (w_rise[g])
      );
    end
  endgenerate

  assign w_pend   = {r_cool_lvl & ~r_cool_mask, r_heat_lvl & ~r_heat_mask, r_pend_lat};
  assign w_rr_req = {w_pend[5], w_pend[4], w_pend[3], w_pend[1], w_pend[0]};
  assign w_pick   = rr_pick(w_rr_req, r_ptr);
  assign w_offer  = (r_state == OFFER);
  assign w_accept = w_offer & evt.evt_ready;

  always_comb begin
    w_clr = 4'b0000;
    if (w_accept) begin
      case (r_code)
        EVT_FD:   w_clr[0] = 1'b1;
        EVT_RD:   w_clr[1] = 1'b1;
        EVT_FIRE: w_clr[2] = 1'b1;
        EVT_WIN:  w_clr[3] = 1'b1;
        default:  w_clr    = 4'b0000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_lat  <= 4'b0000;
      r_heat_lvl  <= 1'b0;
      r_cool_lvl  <= 1'b0;
      r_heat_mask <= 1'b0;
      r_cool_mask <= 1'b0;
    end else begin
      r_pend_lat <= (r_pend_lat & ~w_clr) | w_rise;
      r_heat_lvl <= (st < T_LOW);
      r_cool_lvl <= (st > T_HIGH);
      // A served climate request stays quiet until its level has fallen once
      if (w_accept && (r_code == EVT_HEAT)) r_heat_mask <= 1'b1;
      else if (!r_heat_lvl)                 r_heat_mask <= 1'b0;
      if (w_accept && (r_code == EVT_COOL)) r_cool_mask <= 1'b1;
      else if (!r_cool_lvl)                 r_cool_mask <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_code     <= EVT_NONE;
      r_gidx     <= 3'd0;
      r_ptr      <= 3'd0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_code     <= w_code_nxt;
      r_gidx     <= w_gidx_nxt;
      r_hold_cnt <= w_hold_nxt;
      if (w_accept && (r_code != EVT_FIRE)) begin
        r_ptr <= (r_gidx == 3'd4) ? 3'd0 : r_gidx + 3'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    w_gidx_nxt  = r_gidx;
    w_hold_nxt  = r_hold_cnt;
    case (r_state)
      IDLE: begin
        w_hold_nxt = '0;
        if (w_pend[2]) begin
          w_state_nxt = OFFER;
          w_code_nxt  = EVT_FIRE;
        end else if (w_pick[3]) begin
          w_state_nxt = OFFER;
          w_code_nxt  = rr_code(w_pick[2:0]);
          w_gidx_nxt  = w_pick[2:0];
        end
      end
      OFFER: begin
        if (w_accept) begin
          w_state_nxt = HOLD;
          w_code_nxt  = EVT_NONE;
          w_hold_nxt  = '0;
        end else if (w_pend[2] && (r_code != EVT_FIRE)) begin
          w_code_nxt = EVT_FIRE;
        end else if (((r_code == EVT_HEAT) && !r_heat_lvl) ||
                     ((r_code == EVT_COOL) && !r_cool_lvl)) begin
          w_state_nxt = IDLE;
          w_code_nxt  = EVT_NONE;
        end
      end
      HOLD: begin
        if (w_pend[2]) begin
          w_state_nxt = OFFER;
          w_code_nxt  = EVT_FIRE;
        end else if (r_hold_cnt == C_HOLD_MAX) begin
          w_state_nxt = IDLE;
        end else begin
          w_hold_nxt = r_hold_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_code_nxt  = EVT_NONE;
      end
    endcase
  end

  assign evt.evt_valid = w_offer;
  assign evt.evt_code  = r_code;
  assign pend          = w_pend;
  assign busy          = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_home_event_scheduler.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_home_event_scheduler : directed, table and random checks
// Rev 1.0
// ------------------------------------------------------------------
module tb_home_event_scheduler;

  localparam int DEB = 4;
  localparam int HOLD_CYC = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sfd = 1'b0, srd = 1'b0, sw = 1'b0, sfa = 1'b0;
  logic [6:0] st  = 7'd60;
  logic [5:0] pend;
  logic       busy;

  home_event_scheduler_if evt_if();

  home_event_scheduler dut (
    .clk  (clk),
    .rst  (rst),
    .sfd  (sfd),
    .srd  (srd),
    .sw   (sw),
    .sfa  (sfa),
    .st   (st),
    .evt  (evt_if),
    .pend (pend),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] outs();
    return {evt_if.evt_valid, evt_if.evt_code, pend, busy};
  endfunction

  // ---------------- reference model (event-level view) ----------------
  int       m_cnt[4];
  bit [3:0] m_deb, m_lat;
  bit       m_hl, m_cl, m_hm, m_cm;
  int       m_mode, m_code, m_src, m_ptr, m_left;   // mode 0 idle, 1 offering, 2 settling

  function automatic int rr_bit(input int j);
    int b;
    case (j) 0: b = 0; 1: b = 1; 2: b = 3; 3: b = 4; default: b = 5; endcase
    return b;
  endfunction

  function automatic int rr_cd(input int j);
    int c;
    case (j) 0: c = 1; 1: c = 2; 2: c = 4; 3: c = 5; default: c = 6; endcase
    return c;
  endfunction

  function automatic logic [5:0] m_pend();
    return {m_cl & ~m_cm, m_hl & ~m_hm, m_lat};
  endfunction

  function automatic logic [10:0] m_outs();
    return {m_mode == 1, (m_mode == 1) ? 3'(m_code) : 3'd0, m_pend(), m_mode != 0};
  endfunction

  task automatic model_step();
    logic [5:0] p;
    logic [3:0] raw, rise;
    bit         acc;
    int         pick, j;
    raw = {sw, sfa, srd, sfd};
    if (rst) begin
      for (int s = 0; s < 4; s++) m_cnt[s] = 0;
      m_deb = 0; m_lat = 0; m_hl = 0; m_cl = 0; m_hm = 0; m_cm = 0;
      m_mode = 0; m_code = 0; m_src = 0; m_ptr = 0; m_left = 0;
      return;
    end
    p   = m_pend();
    acc = (m_mode == 1) && evt_if.evt_ready;
    if (!m_hl) m_hm = 0;
    if (!m_cl) m_cm = 0;
    case (m_mode)
      0: begin
        if (p[2]) begin
          m_mode = 1; m_code = 3;
        end else begin
          pick = -1;
          for (int k = 0; k < 5; k++) begin
            j = (m_ptr + k) % 5;
            if (pick < 0 && p[rr_bit(j)]) pick = j;
          end
          if (pick >= 0) begin
            m_mode = 1; m_code = rr_cd(pick); m_src = pick;
          end
        end
      end
      1: begin
        if (acc) begin
          m_mode = 2; m_left = HOLD_CYC;
          case (m_code)
            1: m_lat[0] = 0;
            2: m_lat[1] = 0;
            3: m_lat[2] = 0;
            4: m_lat[3] = 0;
            5: m_hm = 1;
            6: m_cm = 1;
            default: ;
          endcase
          if (m_code != 3) m_ptr = (m_src + 1) % 5;
        end else if (p[2] && m_code != 3) begin
          m_code = 3;
        end else if ((m_code == 5 && !m_hl) || (m_code == 6 && !m_cl)) begin
          m_mode = 0;
        end
      end
      default: begin
        if (p[2]) begin
          m_mode = 1; m_code = 3;
        end else begin
          m_left--;
          if (m_left == 0) m_mode = 0;
        end
      end
    endcase
    rise = 0;
    for (int s = 0; s < 4; s++) begin
      if (raw[s] == m_deb[s]) m_cnt[s] = 0;
      else if (m_cnt[s] == DEB - 1) begin
        m_deb[s] = raw[s]; m_cnt[s] = 0; rise[s] = raw[s];
      end else m_cnt[s]++;
    end
    m_lat = m_lat | rise;
    m_hl  = (st < 7'd50);
    m_cl  = (st > 7'd70);
  endtask

  always @(posedge clk) model_step();

  // ---------------- helpers ----------------
  task automatic do_reset(input int cyc);
    rst = 1'b1;
    repeat (cyc) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_valid(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (evt_if.evt_valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic count_valid(input int cyc, output int n);
    n = 0;
    for (int i = 0; i < cyc; i++) begin
      @(negedge clk);
      if (evt_if.evt_valid) n++;
    end
  endtask

  typedef struct {
    logic [6:0] st;
    logic       valid;
    logic [2:0] code;
    logic [1:0] hc;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int n, b, k, vlost;
    int codes[$];
    int at[$];
    int exp3[3];
    logic [6:0] pick_st;

    tbl[0] = '{7'd49,  1'b1, 3'd5, 2'b01};
    tbl[1] = '{7'd50,  1'b0, 3'd0, 2'b00};
    tbl[2] = '{7'd71,  1'b1, 3'd6, 2'b10};
    tbl[3] = '{7'd70,  1'b0, 3'd0, 2'b00};
    tbl[4] = '{7'd0,   1'b1, 3'd5, 2'b01};
    tbl[5] = '{7'd127, 1'b1, 3'd6, 2'b10};
    tbl[6] = '{7'd60,  1'b0, 3'd0, 2'b00};
    exp3   = '{1, 2, 4};

    evt_if.evt_ready = 1'b0;
    @(negedge clk);
    do_reset(2);
    chk("reset_outputs", 32'(outs()), 32'd0);

    // short pulse must be filtered
    sfd = 1'b1;
    repeat (2) @(negedge clk);
    sfd = 1'b0;
    count_valid(10, n);
    chk("t1_no_event", n, 0);
    chk("t1_pend", 32'(pend), 32'd0);

    // single FD event, accepted on the first valid cycle
    evt_if.evt_ready = 1'b1;
    sfd = 1'b1;
    wait_valid(20, n);
    chk("t2_latency", n, 5);
    chk("t2_code", 32'(evt_if.evt_code), 32'd1);
    b = 1;
    for (int i = 0; i < 30 && busy; i++) begin
      @(negedge clk);
      if (busy) b++;
    end
    chk("t2_busy_cycles", b, 9);
    chk("t2_pend_clear", 32'(pend), 32'd0);
    sfd = 1'b0;
    evt_if.evt_ready = 1'b0;
    repeat (8) @(negedge clk);

    // simultaneous FD/RD/WIN, ready tied high
    do_reset(1);
    evt_if.evt_ready = 1'b1;
    sfd = 1'b1; srd = 1'b1; sw = 1'b1;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (evt_if.evt_valid && evt_if.evt_ready) begin
        codes.push_back(int'(evt_if.evt_code));
        at.push_back(c);
      end
    end
    chk("t3_count", codes.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t3_code%0d", i), (i < codes.size()) ? codes[i] : -1, exp3[i]);
    end
    for (int i = 1; i < 3; i++) begin
      chk($sformatf("t3_gap%0d", i), (i < at.size()) ? at[i] - at[i-1] : -1, 10);
    end
    sfd = 1'b0; srd = 1'b0; sw = 1'b0;
    evt_if.evt_ready = 1'b0;
    repeat (8) @(negedge clk);

    // FIRE displaces an outstanding RD offer
    do_reset(1);
    srd = 1'b1;
    wait_valid(20, n);
    chk("t4_rd_code", 32'(evt_if.evt_code), 32'd2);
    sfa = 1'b1;
    k = -1; vlost = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (!evt_if.evt_valid) vlost++;
      if (evt_if.evt_code == 3'd3) begin
        k = i;
        break;
      end
    end
    chk("t4_fire_switch", k, 5);
    chk("t4_valid_kept", vlost, 0);
    chk("t4_pend_both", 32'(pend), 32'b000110);
    evt_if.evt_ready = 1'b1;
    @(negedge clk);
    evt_if.evt_ready = 1'b0;
    chk("t4_hold", {30'd0, evt_if.evt_valid, busy}, 32'b01);
    chk("t4_rd_kept", 32'(pend), 32'b000010);
    wait_valid(20, n);
    chk("t4_reissue_lat", n, 9);
    chk("t4_reissue_code", 32'(evt_if.evt_code), 32'd2);
    evt_if.evt_ready = 1'b1;
    @(negedge clk);
    evt_if.evt_ready = 1'b0;
    srd = 1'b0; sfa = 1'b0;
    repeat (12) @(negedge clk);

    // temperature classification table (ready low)
    for (int i = 0; i < 7; i++) begin
      st = tbl[i].st;
      repeat (4) @(negedge clk);
      chk($sformatf("t5_vec%0d_st%0d", i, tbl[i].st),
          {21'd0, evt_if.evt_valid, evt_if.evt_code, pend, busy},
          {21'd0, tbl[i].valid, tbl[i].code, tbl[i].hc, 4'b0000, tbl[i].valid});
    end
    st = 7'd49;
    wait_valid(10, n);
    chk("t5_heat_offer", 32'(evt_if.evt_code), 32'd5);
    st = 7'd60;
    repeat (3) @(negedge clk);
    chk("t5_withdraw", {31'd0, evt_if.evt_valid}, 32'd0);
    st = 7'd49;
    evt_if.evt_ready = 1'b1;
    k = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (evt_if.evt_valid) k++;
    end
    chk("t5_heat_masked", k, 1);
    evt_if.evt_ready = 1'b0;
    st = 7'd60;
    repeat (4) @(negedge clk);

    // reset during HOLD with WIN still pending
    do_reset(1);
    evt_if.evt_ready = 1'b1;
    sfd = 1'b1; sw = 1'b1;
    wait_valid(20, n);
    chk("t6_fd_code", 32'(evt_if.evt_code), 32'd1);
    @(negedge clk);
    evt_if.evt_ready = 1'b0;
    sfd = 1'b0; sw = 1'b0;
    chk("t6_in_hold", {30'd0, evt_if.evt_valid, busy}, 32'b01);
    chk("t6_win_pend", 32'(pend), 32'b001000);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_reset_outputs", 32'(outs()), 32'd0);
    rst = 1'b0;
    evt_if.evt_ready = 1'b1;
    count_valid(30, n);
    chk("t6_no_event", n, 0);
    evt_if.evt_ready = 1'b0;

    // randomized run against the model
    do_reset(2);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      chk($sformatf("rand_c%0d", c), 32'(outs()), 32'(m_outs()));
      if ($urandom_range(5) == 0)  sfd = ~sfd;
      if ($urandom_range(5) == 0)  srd = ~srd;
      if ($urandom_range(5) == 0)  sw  = ~sw;
      if ($urandom_range(40) == 0) sfa = ~sfa;
      if ($urandom_range(30) == 0) begin
        case ($urandom_range(5))
          0:       pick_st = 7'd49;
          1:       pick_st = 7'd50;
          2:       pick_st = 7'd70;
          3:       pick_st = 7'd71;
          default: pick_st = 7'($urandom_range(127));
        endcase
        st = pick_st;
      end
      evt_if.evt_ready = 1'($urandom_range(1));
      rst = ($urandom_range(400) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
